two_bit_divider: RTL and testbench

- Sequential restoring divider; the inverse of the two-bit shift-add multiplier path. It recovers the multiplicand from a 32-bit product and an N-bit multiplier operand.
- Accepts dividend c and divisor b, then produces a 32-bit quotient and an N-bit remainder, one quotient bit per cycle.
- Sits on the receive side of the multiply datapath. It checks products (exact flag) and regenerates operands.
- Single request in flight; a ready/vld handshake on the input side and a result_vld pulse on the output side.

---
 rtl/two_bit_divider.sv | 126 ++++++++++++
 tb/tb_two_bit_divider.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/two_bit_divider.sv
// Sequential restoring divider: c / b -> 32-bit quotient and N-bit remainder, one quotient bit per clock.
// Single request in flight; ready gates acceptance and result_vld pulses for one cycle in DONE.
module two_bit_divider #(
  parameter int N = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   c,
  input  logic [N-1:0]  b,
  input  logic          vld,
  output logic          ready,
  output logic [31:0]   q,
  output logic [N-1:0]  r,
  output logic          exact,
  output logic          div_by_zero,
  output logic          result_vld
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [N-1:0]  b_reg;
  logic [N-1:0]  rem;
  logic [31:0]   quo;
  logic [4:0]    cnt;

  logic [N:0]    shifted;
  logic [N:0]    trial;
  logic          fits;
  logic [N-1:0]  rem_nxt;
  logic [31:0]   quo_nxt;
  logic          last;

  // The remainder stays below b, so one extra bit holds the shifted-in value.
  always_comb begin
    shifted = {rem, quo[31]};
    trial   = shifted - {1'b0, b_reg};
    fits    = (shifted >= {1'b0, b_reg});
    rem_nxt = fits ? trial[N-1:0] : shifted[N-1:0];
    quo_nxt = {quo[30:0], fits};
    last    = (cnt == 5'd31);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    ready      = 1'b0;
    result_vld = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (vld) begin
          state_nxt = (b == '0) ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        result_vld = 1'b1;
        state_nxt  = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b_reg       <= '0;
      rem         <= '0;
      quo         <= '0;
      cnt         <= '0;
      q           <= '0;
      r           <= '0;
      exact       <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (vld) begin
            b_reg <= b;
            if (b != '0) begin
              rem <= '0;
              quo <= c;
              cnt <= '0;
            end else begin
              q           <= 32'hFFFF_FFFF;
              r           <= c[N-1:0];
              div_by_zero <= 1'b1;
              exact       <= 1'b0;
            end
          end
        end
        BUSY: begin
          rem <= rem_nxt;
          quo <= quo_nxt;
          cnt <= cnt + 5'd1;
          if (last) begin
            q           <= quo_nxt;
            r           <= rem_nxt;
            exact       <= (rem_nxt == '0);
            div_by_zero <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_two_bit_divider.sv
// Randomized and directed scoreboard bench for two_bit_divider against plain-arithmetic division.
module tb_two_bit_divider;
  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   c;
  logic [N-1:0]  b;
  logic          vld;
  logic          ready;
  logic [31:0]   q;
  logic [N-1:0]  r;
  logic          exact;
  logic          div_by_zero;
  logic          result_vld;

  two_bit_divider #(.N(N)) dut (
    .clk(clk), .rst(rst), .c(c), .b(b), .vld(vld), .ready(ready),
    .q(q), .r(r), .exact(exact), .div_by_zero(div_by_zero), .result_vld(result_vld)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]  q;
    logic [N-1:0] r;
    logic         ex;
    logic         dz;
    int           acc;
  } exp_t;

  exp_t sb[$];
  exp_t got;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor: every result_vld must match the oldest outstanding request.
  always @(negedge clk) begin
    if (!rst && result_vld) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL spurious_result_vld: got 1 expected 0 (cycle %0d)", cyc);
      end else begin
        got = sb.pop_front();
        chk("q", 64'(q), 64'(got.q));
        chk("r", 64'(r), 64'(got.r));
        chk("exact", 64'(exact), 64'(got.ex));
        chk("div_by_zero", 64'(div_by_zero), 64'(got.dz));
        if (got.dz)
          chk("dz_latency_le1", 64'((cyc - got.acc) <= 1), 64'd1);
        else
          chk("latency", 64'(cyc - got.acc), 64'd32);
      end
    end
  end

  task automatic issue(input logic [31:0] cc, input logic [N-1:0] bb);
    exp_t e;
    int t = 0;
    while (!ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!ready) begin
      chk("ready_timeout", 64'(ready), 64'd1);
      return;
    end
    if (bb == '0) begin
      e.q  = 32'hFFFF_FFFF;
      e.r  = cc[N-1:0];
      e.ex = 1'b0;
      e.dz = 1'b1;
    end else begin
      e.q  = cc / 32'(bb);
      e.r  = N'(cc % 32'(bb));
      e.ex = ((cc % 32'(bb)) == 0);
      e.dz = 1'b0;
    end
    e.acc = cyc + 1;
    sb.push_back(e);
    c   = cc;
    b   = bb;
    vld = 1'b1;
    @(negedge clk);
    vld = 1'b0;
    c   = $urandom;
    b   = N'($urandom);
    chk("ready_after_accept", 64'(ready), 64'd0);
  endtask

  task automatic wait_done();
    int t = 0;
    while (sb.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      chk("result_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
  endtask

  initial begin
    rst = 1'b1;
    vld = 1'b0;
    c   = '0;
    b   = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 64'(ready), 64'd1);
    chk("rst_q", 64'(q), 64'd0);
    chk("rst_r", 64'(r), 64'd0);
    chk("rst_exact", 64'(exact), 64'd0);
    chk("rst_dz", 64'(div_by_zero), 64'd0);
    chk("rst_result_vld", 64'(result_vld), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    issue(32'h0000_5B04, 4'h5);  wait_done();
    issue(32'd100, 4'd7);        wait_done();
    issue(32'd7, 4'd9);          wait_done();
    issue(32'hDEAD_BEEF, 4'h0);  wait_done();
    @(negedge clk);
    chk("ready_after_dz", 64'(ready), 64'd1);
    issue(32'hFFFF_FFFF, 4'h1);  wait_done();
    issue(32'hFFFF_FFFF, 4'hF);  wait_done();

    // A request presented while busy must vanish without a result.
    issue(32'd100, 4'd7);
    repeat (9) @(negedge clk);
    c   = 32'd50;
    b   = 4'd5;
    vld = 1'b1;
    chk("ready_busy", 64'(ready), 64'd0);
    @(negedge clk);
    vld = 1'b0;
    wait_done();
    repeat (40) @(negedge clk);
    chk("hold_q", 64'(q), 64'd14);
    chk("hold_r", 64'(r), 64'd2);

    // Asynchronous reset in the middle of a division.
    issue(32'h1234_5678, 4'd3);
    repeat (14) @(negedge clk);
    rst = 1'b1;
    #1;
    sb.delete();
    chk("midrst_ready", 64'(ready), 64'd1);
    chk("midrst_q", 64'(q), 64'd0);
    chk("midrst_r", 64'(r), 64'd0);
    chk("midrst_exact", 64'(exact), 64'd0);
    chk("midrst_dz", 64'(div_by_zero), 64'd0);
    chk("midrst_result_vld", 64'(result_vld), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    issue(32'd1000, 4'd9);       wait_done();

    for (int i = 0; i < 25; i++) begin
      logic [31:0]  rc;
      logic [N-1:0] rb;
      rc = $urandom;
      rb = (i % 8 == 7) ? '0 : N'($urandom_range(1, (1 << N) - 1));
      if (i % 5 == 0) rc = rc >> $urandom_range(0, 31);
      issue(rc, rb);
      wait_done();
    end

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
